// File: rtl/ipd_controller_mc_if.sv
// Bus bundle for the multi-channel IPD controller: setpoints, measurements,
// shared gains and hold mask in; control outputs and status flags out.
interface ipd_controller_mc_if #(
   parameter int W   = 12,
   parameter int NCH = 2
);
   logic [NCH*W-1:0] r;
   logic [NCH*W-1:0] y;
   logic [W-1:0]     kp;
   logic [W-1:0]     ki;
   logic [W-1:0]     kd;
   logic [NCH-1:0]   hold;
   logic [NCH*W-1:0] u;
   logic             listo;
   logic [NCH-1:0]   sat;
   logic             overrun;

   modport master (
      output r, y, kp, ki, kd, hold,
      input  u, listo, sat, overrun
   );

   modport slave (
      input  r, y, kp, ki, kd, hold,
      output u, listo, sat, overrun
   );
endinterface

// File: rtl/ipd_controller_mc.sv
// Multi-channel I-PD controller. A sample counter fires a tick every DIV
// cycles; on the tick all inputs are snapshotted and one shared datapath
// walks the channels through ERR -> INT -> OUT. Every output is then
// committed together in DONE with a one-cycle listo pulse.
module ipd_controller_mc #(
   parameter int W    = 12,
   parameter int FRAC = 8,
   parameter int NCH  = 2,
   parameter int DIV  = 250000
) (
   input  logic              clk,
   input  logic              reset,
   ipd_controller_mc_if.slave bus
);
   localparam int EW = W + 1;        // error / delta width, lossless
   localparam int PW = 2 * EW;       // full product width
   localparam int AW = PW + 2;       // accumulator headroom before clipping
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = $clog2(DIV);
   localparam logic [TW-1:0]        TICK_AT = TW'(DIV - 1);
   localparam logic [CW-1:0]        LAST_C  = CW'(NCH - 1);
   localparam logic signed [AW-1:0] SMAX    = AW'(2 ** (W - 1) - 1);
   localparam logic signed [AW-1:0] SMIN    = ~SMAX;

   typedef enum logic [2:0] {IDLE, ERR, INT, OUT, DONE} state_t;

   // Clip to the signed W-bit range.
   function automatic logic signed [W-1:0] sat_w(input logic signed [AW-1:0] x);
      if (x > SMAX)      return SMAX[W-1:0];
      else if (x < SMIN) return SMIN[W-1:0];
      else               return x[W-1:0];
   endfunction

   function automatic logic clipped(input logic signed [AW-1:0] x);
      return (x > SMAX) || (x < SMIN);
   endfunction

   // Unsigned gain times signed operand, full width, then arithmetic rescale.
   function automatic logic signed [PW-1:0] gmul(input logic [W-1:0] g,
                                                 input logic signed [EW-1:0] v);
      logic signed [EW-1:0] gx;
      gx = signed'({1'b0, g});
      return (PW'(gx) * PW'(v)) >>> FRAC;
   endfunction

   state_t          state, state_nx;
   logic [TW-1:0]   cnt;
   logic [CW-1:0]   c;
   logic            tick, last_c;
   logic            snap, en_err, en_int, en_out, fin;
   logic            listo_q, overrun_q, first_q;

   logic [NCH*W-1:0] r_s, y_s;
   logic [NCH-1:0]   hold_s;
   logic [W-1:0]     kp_s, ki_s, kd_s;

   logic signed [W-1:0]  i_q     [NCH];
   logic signed [W-1:0]  y_prev  [NCH];
   logic signed [W-1:0]  unew_q  [NCH];
   logic [NCH-1:0]       iclip_q, sclip_q;
   logic [NCH*W-1:0]     u_q;
   logic [NCH-1:0]       sat_q;

   logic signed [W-1:0]  r_c, y_c, yp_c;
   logic signed [EW-1:0] e_nx, dy_nx, e_p1, dy_p1;
   logic signed [PW-1:0] p_term, d_term;
   logic signed [AW-1:0] acc_i, acc_u;
   logic signed [W-1:0]  u_new_c;
   logic                 uclip_c;
   logic [NCH*W-1:0]     u_all;
   logic [NCH-1:0]       sat_all;

   assign tick   = (cnt == TICK_AT);
   assign last_c = (c == LAST_C);

   assign r_c  = r_s[int'(c)*W +: W];
   assign y_c  = y_s[int'(c)*W +: W];
   assign yp_c = y_prev[c];

   // Stage ERR: lossless error and measurement delta.
   assign e_nx  = EW'(r_c) - EW'(y_c);
   assign dy_nx = EW'(y_c) - EW'(yp_c);

   // Stage INT: integrator accumulate.
   assign acc_i = AW'(i_q[c]) + AW'(gmul(ki_s, e_p1));

   // Stage OUT: proportional and derivative act on the measurement only.
   assign p_term  = gmul(kp_s, EW'(y_c));
   assign d_term  = first_q ? '0 : gmul(kd_s, dy_p1);
   assign acc_u   = AW'(i_q[c]) - AW'(p_term) - AW'(d_term);
   assign u_new_c = sat_w(acc_u);
   assign uclip_c = clipped(acc_u) | iclip_q[c];

   // Merge the channel finishing this cycle with the ones already computed.
   always_comb begin
      u_all   = '0;
      sat_all = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         u_all[ch*W +: W] = (CW'(ch) == c) ? u_new_c : unew_q[ch];
         sat_all[ch]      = (CW'(ch) == c) ? uclip_c : sclip_q[ch];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // FSM next state and stage strobes.
   always_comb begin
      state_nx = state;
      snap     = 1'b0;
      en_err   = 1'b0;
      en_int   = 1'b0;
      en_out   = 1'b0;
      fin      = 1'b0;
      case (state)
         IDLE: if (tick) begin
            snap     = 1'b1;
            state_nx = ERR;
         end
         ERR: begin
            en_err   = 1'b1;
            state_nx = INT;
         end
         INT: begin
            en_int   = 1'b1;
            state_nx = OUT;
         end
         OUT: begin
            en_out   = 1'b1;
            fin      = last_c;
            state_nx = last_c ? DONE : ERR;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Sample counter, channel index, listo pulse and sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         c         <= '0;
         listo_q   <= 1'b0;
         overrun_q <= 1'b0;
         first_q   <= 1'b1;
      end else begin
         cnt     <= tick ? '0 : cnt + TW'(1);
         listo_q <= fin;
         if (tick && state != IDLE) overrun_q <= 1'b1;
         if (snap)                  c <= '0;
         else if (en_out && !last_c) c <= c + CW'(1);
         if (fin) first_q <= 1'b0;
      end
   end

   // Controller state that must come up cleared: integrators, history, outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NCH; ch++) begin
            i_q[ch]    <= '0;
            y_prev[ch] <= '0;
         end
         u_q   <= '0;
         sat_q <= '0;
      end else begin
         if (en_int && !hold_s[c]) i_q[c] <= sat_w(acc_i);
         if (en_out)               y_prev[c] <= y_c;
         if (fin) begin
            u_q   <= u_all;
            sat_q <= sat_all;
         end
      end
   end

   // Snapshot and inter-stage registers; always written before being read.
   always_ff @(posedge clk) begin
      if (snap) begin
         r_s    <= bus.r;
         y_s    <= bus.y;
         hold_s <= bus.hold;
         kp_s   <= bus.kp;
         ki_s   <= bus.ki;
         kd_s   <= bus.kd;
      end
      if (en_err) begin
         e_p1  <= e_nx;
         dy_p1 <= dy_nx;
      end
      if (en_int) iclip_q[c] <= hold_s[c] ? 1'b0 : clipped(acc_i);
      if (en_out) begin
         unew_q[c]  <= u_new_c;
         sclip_q[c] <= uclip_c;
      end
   end

   assign bus.u       = u_q;
   assign bus.sat     = sat_q;
   assign bus.listo   = listo_q;
   assign bus.overrun = overrun_q;
endmodule
